// File: rtl/nano_dmem_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nano_dmem_rr_arbiter
// Description : Round-robin arbiter that shares one single-port data SRAM
//               between NUM_CORE NanoCore data ports. Grants at most one
//               access per cycle and tracks in-flight accesses through a
//               RD_LATENCY-deep ID pipeline. Each response (read data or
//               write ack) is steered back to the core that issued it.
// Ports       : i_clk, i_rst_n             clock, async active-low reset
//               i_req/i_we/i_addr/
//               i_wstrb/i_wdata            per-core request side (flat vectors)
//               o_gnt                      one-hot grant, same cycle as accept
//               o_valid/o_rdata            one-hot response strobe + shared data
//               o_mem_*                    SRAM access side
//               i_mem_rdy/i_mem_rdata      SRAM ready and read data
// Revision    : 1.0 - initial release
// ============================================================================
module nano_dmem_rr_arbiter #(
  parameter int NUM_CORE   = 4,
  parameter int RD_LATENCY = 1,
  parameter int ID_W       = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_CORE-1:0]   i_req,
  input  logic [NUM_CORE-1:0]   i_we,
  input  logic [NUM_CORE*32-1:0] i_addr,
  input  logic [NUM_CORE*4-1:0] i_wstrb,
  input  logic [NUM_CORE*32-1:0] i_wdata,
  output logic [NUM_CORE-1:0]   o_gnt,
  output logic [NUM_CORE-1:0]   o_valid,
  output logic [31:0]           o_rdata,
  output logic                  o_mem_rden,
  output logic                  o_mem_wren,
  output logic [31:0]           o_mem_addr,
  output logic [3:0]            o_mem_wstrb,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_rdy,
  input  logic [31:0]           i_mem_rdata
);

  localparam int C_LAST = RD_LATENCY - 1;

  // Round-robin pointer: the core with highest priority this cycle.
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Held copies of the last granted access, driven to the SRAM when idle.
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;

  // In-flight ID pipeline, stage 0 loaded in the grant cycle.
  logic [RD_LATENCY-1:0]           vld_q, vld_d;
  logic [RD_LATENCY-1:0]           we_q, we_d;
  logic [RD_LATENCY-1:0][ID_W-1:0] id_q, id_d;

  logic            found_hi, found_lo;
  logic [ID_W-1:0] idx_hi, idx_lo;
  logic [ID_W-1:0] gnt_idx;
  logic            accept;
  logic            sel_we;
  logic [31:0]     sel_addr;
  logic [3:0]      sel_wstrb;
  logic [31:0]     sel_wdata;

  // Rotating priority: the lowest requester at or above the pointer wins;
  // if none exists the search wraps to the lowest requester overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (i_req[c] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = ID_W'(c);
      end
      if (i_req[c] && (ID_W'(c) >= ptr_q) && !found_hi) begin
        found_hi = 1'b1;
        idx_hi   = ID_W'(c);
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
    // Reset forces every output low, including the combinational grant.
    accept  = i_rst_n & i_mem_rdy & found_lo;
  end

  // Request mux for the winning core.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      if (gnt_idx == ID_W'(c)) begin
        sel_we    = i_we[c];
        sel_addr  = i_addr[c*32 +: 32];
        sel_wstrb = i_wstrb[c*4 +: 4];
        sel_wdata = i_wdata[c*32 +: 32];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    if (accept) begin
      ptr_d   = (gnt_idx == ID_W'(NUM_CORE - 1)) ? '0 : gnt_idx + ID_W'(1);
      addr_d  = sel_addr;
      wstrb_d = sel_wstrb;
      wdata_d = sel_wdata;
    end

    vld_d    = '0;
    we_d     = '0;
    id_d     = '0;
    vld_d[0] = accept;
    we_d[0]  = sel_we;
    id_d[0]  = gnt_idx;
    for (int s = 1; s < RD_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      we_d[s]  = we_q[s-1];
      id_d[s]  = id_q[s-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q   <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      vld_q   <= '0;
      we_q    <= '0;
      id_q    <= '0;
    end else begin
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      vld_q   <= vld_d;
      we_q    <= we_d;
      id_q    <= id_d;
    end
  end

  // Output decode.
  always_comb begin
    o_gnt   = '0;
    o_valid = '0;
    for (int c = 0; c < NUM_CORE; c++) begin
      o_gnt[c]   = accept & (gnt_idx == ID_W'(c));
      o_valid[c] = vld_q[C_LAST] & (id_q[C_LAST] == ID_W'(c));
    end
    // Write acks carry zero data; the SRAM bus is ignored for them.
    o_rdata     = (vld_q[C_LAST] && !we_q[C_LAST]) ? i_mem_rdata : 32'h0;
    o_mem_rden  = accept & ~sel_we;
    o_mem_wren  = accept & sel_we;
    o_mem_addr  = accept ? sel_addr  : addr_q;
    o_mem_wstrb = accept ? sel_wstrb : wstrb_q;
    o_mem_wdata = accept ? sel_wdata : wdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_nano_dmem_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_nano_dmem_rr_arbiter
// Description : Self-checking bench for nano_dmem_rr_arbiter (4 cores,
//               3-cycle SRAM latency): grant-sequence vector table, directed
//               read/write/reset sequences and a randomized phase checked
//               against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nano_dmem_rr_arbiter;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req, we;
  logic [N*32-1:0] addr, wdata;
  logic [N*4-1:0] wstrb;
  logic [N-1:0]  gnt, valid;
  logic [31:0]   rdata;
  logic          mem_rden, mem_wren, mem_rdy;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;

  nano_dmem_rr_arbiter #(.NUM_CORE(N), .RD_LATENCY(LAT), .ID_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(req), .i_we(we), .i_addr(addr), .i_wstrb(wstrb), .i_wdata(wdata),
    .o_gnt(gnt), .o_valid(valid), .o_rdata(rdata),
    .o_mem_rden(mem_rden), .o_mem_wren(mem_wren), .o_mem_addr(mem_addr),
    .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_rdy(mem_rdy), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_core(input int c, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] d);
    we[c]            = w;
    addr[c*32 +: 32] = a;
    wstrb[c*4 +: 4]  = s;
    wdata[c*32 +: 32] = d;
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic [3:0] gnt;
    logic [3:0] vld;
  } vec_t;
  vec_t tbl[19];

  // ---------------- reference model state ----------------
  typedef struct { int due; int core; logic w; logic [31:0] data; } resp_t;
  typedef struct { int due; logic [31:0] data; } sram_t;
  resp_t rq[$];
  sram_t sq[$];
  int          m_ptr;
  int          cyc;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [N-1:0] pend;
  logic [N-1:0] r_we;
  logic [31:0] r_addr [N];
  logic [3:0]  r_wstrb [N];
  logic [31:0] r_wdata [N];

  task automatic step(input bit gen);
    int k, best, d;
    logic [3:0]  e_gnt, e_vld;
    logic [31:0] e_rdata;
    resp_t r;
    sram_t s;
    for (int c = 0; c < N; c++) begin
      if (pend[c]) begin
        if (!gen || $urandom_range(0, 15) == 0) pend[c] = 1'b0;
      end else if (gen && $urandom_range(0, 2) == 0) begin
        pend[c]    = 1'b1;
        r_we[c]    = 1'($urandom_range(0, 1));
        r_addr[c]  = $urandom & 32'h0FFF_FFFC;
        r_wstrb[c] = 4'($urandom_range(0, 15));
        r_wdata[c] = $urandom;
      end
      set_core(c, r_we[c], r_addr[c], r_wstrb[c], r_wdata[c]);
    end
    req     = pend;
    mem_rdy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (sq.size() > 0 && sq[0].due == cyc) begin
      s = sq.pop_front();
      mem_rdata = s.data;
    end else begin
      mem_rdata = $urandom;
    end
    #1;
    // Grant: requester with the smallest rotational distance from the pointer.
    k = -1;
    best = N;
    if (mem_rdy) begin
      for (int c = 0; c < N; c++) begin
        if (pend[c]) begin
          d = (c - m_ptr + N) % N;
          if (d < best) begin best = d; k = c; end
        end
      end
    end
    e_gnt = (k >= 0) ? 4'(1 << k) : 4'b0;
    chk("rand_gnt", 32'(gnt), 32'(e_gnt));
    chk("rand_rden", 32'(mem_rden), (k >= 0 && !r_we[k]) ? 32'd1 : 32'd0);
    chk("rand_wren", 32'(mem_wren), (k >= 0 && r_we[k]) ? 32'd1 : 32'd0);
    chk("rand_maddr", mem_addr, (k >= 0) ? r_addr[k] : m_addr);
    chk("rand_mwstrb", 32'(mem_wstrb), 32'((k >= 0) ? r_wstrb[k] : m_wstrb));
    chk("rand_mwdata", mem_wdata, (k >= 0) ? r_wdata[k] : m_wdata);
    e_vld = 4'b0;
    e_rdata = 32'h0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      r = rq.pop_front();
      e_vld = 4'(1 << r.core);
      e_rdata = r.w ? 32'h0 : r.data;
    end
    chk("rand_valid", 32'(valid), 32'(e_vld));
    chk("rand_rdata", rdata, e_rdata);
    if (k >= 0) begin
      m_ptr   = (k + 1) % N;
      m_addr  = r_addr[k];
      m_wstrb = r_wstrb[k];
      m_wdata = r_wdata[k];
      rq.push_back('{cyc + LAT, k, r_we[k], data_of(r_addr[k])});
      if (!r_we[k]) sq.push_back('{cyc + LAT, data_of(r_addr[k])});
      pend[k] = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    // Fairness, skip/wrap and back-pressure, starting from reset (ptr=0).
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 4'b0000};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 4'b0000};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 4'b0001};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 4'b0010};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 4'b0100};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 4'b1000};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0001, 4'b0001};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0100, 4'b0010};
    tbl[9]  = '{4'b0011, 1'b0, 4'b0000, 4'b0100};
    tbl[10] = '{4'b0011, 1'b0, 4'b0000, 4'b0001};
    tbl[11] = '{4'b0011, 1'b0, 4'b0000, 4'b0100};
    tbl[12] = '{4'b0011, 1'b1, 4'b0001, 4'b0000};
    tbl[13] = '{4'b0011, 1'b1, 4'b0010, 4'b0000};
    tbl[14] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
    tbl[15] = '{4'b1000, 1'b1, 4'b1000, 4'b0001};
    tbl[16] = '{4'b0000, 1'b1, 4'b0000, 4'b0010};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 4'b0000};
    tbl[18] = '{4'b0000, 1'b1, 4'b0000, 4'b1000};

    rst_n = 1'b0;
    req = 4'b1111;
    we = '0;
    addr = '0;
    wstrb = '0;
    wdata = '0;
    mem_rdy = 1'b1;
    mem_rdata = 32'h0;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 32'h10 * (c + 1), 4'hF, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rden", 32'(mem_rden), 32'h0);
    chk("reset_wren", 32'(mem_wren), 32'h0);
    chk("reset_maddr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      req = tbl[i].req;
      mem_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].vld));
      @(negedge clk);
    end

    // Read return: core2 reads 0x40, SRAM answers 0xDEADBEEF after LAT cycles.
    req = 4'b0100;
    mem_rdy = 1'b1;
    set_core(2, 1'b0, 32'h0000_0040, 4'hF, 32'h0);
    #1;
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_rden", 32'(mem_rden), 32'h1);
    chk("rd_maddr", mem_addr, 32'h40);
    @(negedge clk);
    req = 4'b0000;
    for (int i = 1; i <= LAT + 1; i++) begin
      mem_rdata = (i == LAT) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      chk($sformatf("rd_valid_c%0d", i), 32'(valid), (i == LAT) ? 32'h4 : 32'h0);
      chk($sformatf("rd_rdata_c%0d", i), rdata, (i == LAT) ? 32'hDEAD_BEEF : 32'h0);
      @(negedge clk);
    end

    // Mixed stream: core1 write then core3 read on consecutive cycles.
    req = 4'b0010;
    set_core(1, 1'b1, 32'h100, 4'b0011, 32'h1122_3344);
    #1;
    chk("mix_gnt_w", 32'(gnt), 32'h2);
    chk("mix_wren", 32'(mem_wren), 32'h1);
    chk("mix_rden_w", 32'(mem_rden), 32'h0);
    chk("mix_wstrb", 32'(mem_wstrb), 32'h3);
    chk("mix_wdata", mem_wdata, 32'h1122_3344);
    @(negedge clk);
    req = 4'b1000;
    set_core(3, 1'b0, 32'h200, 4'hF, 32'h0);
    #1;
    chk("mix_gnt_r", 32'(gnt), 32'h8);
    chk("mix_rden_r", 32'(mem_rden), 32'h1);
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("mix_hold_addr", mem_addr, 32'h200);
    chk("mix_idle_valid", 32'(valid), 32'h0);
    @(negedge clk);
    mem_rdata = 32'h1234_5678;
    #1;
    chk("mix_wack_valid", 32'(valid), 32'h2);
    chk("mix_wack_rdata", rdata, 32'h0);
    @(negedge clk);
    mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("mix_rd_valid", 32'(valid), 32'h8);
    chk("mix_rd_rdata", rdata, 32'hCAFE_F00D);
    @(negedge clk);
    #1;
    chk("mix_end_valid", 32'(valid), 32'h0);
    @(negedge clk);

    // Reset mid-traffic: in-flight responses are discarded.
    req = 4'b1111;
    for (int c = 0; c < N; c++) set_core(c, 1'b0, 32'h300 + 32'(c * 4), 4'hF, 32'h0);
    #1;
    chk("rst_pre_gnt0", 32'(gnt), 32'h1);
    @(negedge clk);
    #1;
    chk("rst_pre_gnt1", 32'(gnt), 32'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'h0);
    chk("rst_mid_valid", 32'(valid), 32'h0);
    chk("rst_mid_rden", 32'(mem_rden), 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    chk("rst_mid_maddr", mem_addr, 32'h0);
    @(negedge clk);
    req = 4'b0000;
    mem_rdata = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    for (int i = 0; i <= LAT; i++) begin
      #1;
      chk($sformatf("rst_drain_valid%0d", i), 32'(valid), 32'h0);
      chk($sformatf("rst_drain_rdata%0d", i), rdata, 32'h0);
      @(negedge clk);
    end
    req = 4'b1111;
    #1;
    chk("rst_first_gnt", 32'(gnt), 32'h1);
    @(negedge clk);

    // Randomized phase from a fresh reset.
    req = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    cyc = 0;
    m_addr = '0;
    m_wstrb = '0;
    m_wdata = '0;
    pend = '0;
    r_we = '0;
    for (int c = 0; c < N; c++) begin
      r_addr[c] = '0;
      r_wstrb[c] = '0;
      r_wdata[c] = '0;
    end
    rq.delete();
    sq.delete();
    repeat (600) step(1'b1);
    repeat (LAT + 2) step(1'b0);
    total++;
    if (rq.size() != 0) begin
      bad++;
      $display("FAIL rand_drain: got %0d outstanding expected 0", rq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
